delay_latch_rx: RTL and testbench

//  Receiving end of the delay-programming interface: accepts a shared DW-bit data bus plus two active-low

---
 rtl/delay_pkg.sv | 15 +
 rtl/delay_latch_chan.sv | 111 +++++++++++
 rtl/delay_latch_rx.sv | 90 +++++++++
 tb/tb_delay_latch_rx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/delay_pkg.sv
// Shared parameters and channel state encoding for the delay-latch receiver.
package delay_pkg;

  localparam int DW_DEF        = 10;
  localparam int MIN_PULSE_DEF = 32;
  localparam int CNT_W_DEF     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOW     = 2'd1,
    CAPTURE = 2'd2,
    REJECT  = 2'd3
  } chan_state_t;

endpackage

// File: rtl/delay_latch_chan.sv
// One delay-line channel: latch-enable FSM with pulse-width check, hold register,
// and a down-counting delay engine driven by the shared trigger edge.
module delay_latch_chan
  import delay_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          res,
  input  logic          len_q,
  input  logic          arm,
  input  logic          ovl,
  input  logic          trig_edge,
  input  logic [DW-1:0] d_q,
  output logic [DW-1:0] dout,
  output logic          upd,
  output logic          trig_x,
  output logic          rej_short,
  output logic          rej_ovl
);

  localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] W_MAX = '1;

  chan_state_t      state, state_nxt;
  logic [CNT_W-1:0] width;
  logic [DW-1:0]    hold;
  logic [DW-1:0]    cnt;
  logic             busy;
  logic             armed;
  logic             ovl_seen;
  logic             enter, stay, load;

  // A pulse only counts once a genuine high level has been seen since reset,
  // so a latch enable already low when reset drops is ignored until released.
  assign enter = (state == IDLE) && armed && !len_q;
  assign stay  = (state == LOW) && !len_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enter) state_nxt = LOW;
      LOW:     if (len_q) state_nxt = (width >= MIN_W && !ovl_seen) ? CAPTURE : REJECT;
      CAPTURE: state_nxt = IDLE;
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load      = (state == CAPTURE);
    rej_short = (state == REJECT) && (width < MIN_W);
    rej_ovl   = (state == REJECT) && ovl_seen;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      armed    <= 1'b0;
      width    <= '0;
      ovl_seen <= 1'b0;
    end else begin
      armed <= armed | arm;
      if (enter) begin
        width    <= CNT_W'(1);
        ovl_seen <= ovl;
      end else if (stay) begin
        width    <= (width == W_MAX) ? width : width + 1'b1;
        ovl_seen <= ovl_seen | ovl;
      end
    end
  end

  // Transparent-latch emulation: follows the bus while the enable is low.
  always_ff @(posedge clk) begin
    if (enter || stay) hold <= d_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      dout <= '0;
      upd  <= 1'b0;
    end else begin
      upd <= load;
      if (load) dout <= hold;
    end
  end

  // Delay engine: the count is snapshotted at the edge, later dout updates do not disturb it.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end else if (trig_edge) begin
      busy <= 1'b1;
      cnt  <= dout;
    end
  end

  assign trig_x = busy && (cnt == '0);

endmodule

// File: rtl/delay_latch_rx.sv
// Delay-programming receiver: registers the pins, detects enable overlap,
// keeps sticky error flags and runs two independent latch/delay channels.
module delay_latch_rx
  import delay_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          res,
  input  logic [DW-1:0] d,
  input  logic          lena,
  input  logic          lenb,
  input  logic          clr_err,
  input  logic          trig,
  output logic [DW-1:0] dout_a,
  output logic [DW-1:0] dout_b,
  output logic          upd_a,
  output logic          upd_b,
  output logic          trig_a,
  output logic          trig_b,
  output logic [1:0]    err
);

  logic          lena_q, lenb_q, trig_q, trig_p, primed;
  logic [DW-1:0] d_q;
  logic          ovl, trig_edge;
  logic          rej_short_a, rej_short_b, rej_ovl_a, rej_ovl_b;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      lena_q <= 1'b1;
      lenb_q <= 1'b1;
      trig_q <= 1'b0;
      trig_p <= 1'b0;
      primed <= 1'b0;
    end else begin
      lena_q <= lena;
      lenb_q <= lenb;
      trig_q <= trig;
      trig_p <= trig_q;
      primed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    d_q <= d;
  end

  assign ovl       = !lena_q && !lenb_q;
  assign trig_edge = trig_q && !trig_p;

  // Set has priority over a simultaneous clear so no error is ever lost.
  always_ff @(posedge clk or posedge res) begin
    if (res) err <= 2'b00;
    else     err <= (err & ~{2{clr_err}}) | {rej_ovl_a | rej_ovl_b, rej_short_a | rej_short_b};
  end

  delay_latch_chan #(.DW(DW), .MIN_PULSE(MIN_PULSE), .CNT_W(CNT_W)) u_chan_a (
    .clk       (clk),
    .res       (res),
    .len_q     (lena_q),
    .arm       (lena_q && primed),
    .ovl       (ovl),
    .trig_edge (trig_edge),
    .d_q       (d_q),
    .dout      (dout_a),
    .upd       (upd_a),
    .trig_x    (trig_a),
    .rej_short (rej_short_a),
    .rej_ovl   (rej_ovl_a)
  );

  delay_latch_chan #(.DW(DW), .MIN_PULSE(MIN_PULSE), .CNT_W(CNT_W)) u_chan_b (
    .clk       (clk),
    .res       (res),
    .len_q     (lenb_q),
    .arm       (lenb_q && primed),
    .ovl       (ovl),
    .trig_edge (trig_edge),
    .d_q       (d_q),
    .dout      (dout_b),
    .upd       (upd_b),
    .trig_x    (trig_b),
    .rej_short (rej_short_b),
    .rej_ovl   (rej_ovl_b)
  );

endmodule

// File: tb/tb_delay_latch_rx.sv
// Directed bench for delay_latch_rx: capture, short pulse, overlap, delays, saturation, reset.
module tb_delay_latch_rx;

  logic       clk = 1'b0;
  logic       res;
  logic [9:0] d;
  logic       lena, lenb, clr_err, trig;
  logic [9:0] dout_a, dout_b;
  logic       upd_a, upd_b, trig_a, trig_b;
  logic [1:0] err;

  int n_cmp = 0;
  int n_bad = 0;
  int ua_cnt = 0;
  int ub_cnt = 0;
  int ua0, ub0, first_a;

  always #5 clk = ~clk;

  delay_latch_rx dut (
    .clk     (clk),
    .res     (res),
    .d       (d),
    .lena    (lena),
    .lenb    (lenb),
    .clr_err (clr_err),
    .trig    (trig),
    .dout_a  (dout_a),
    .dout_b  (dout_b),
    .upd_a   (upd_a),
    .upd_b   (upd_b),
    .trig_a  (trig_a),
    .trig_b  (trig_b),
    .err     (err)
  );

  always @(posedge clk) begin
    if (upd_a) ua_cnt <= ua_cnt + 1;
    if (upd_b) ub_cnt <= ub_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input bit chan_b, input int n, input logic [9:0] val);
    d = val;
    if (chan_b) lenb = 1'b0; else lena = 1'b0;
    step(n);
    if (chan_b) lenb = 1'b1; else lena = 1'b1;
  endtask

  initial begin
    res = 1'b1; d = '0; lena = 1'b1; lenb = 1'b1; clr_err = 1'b0; trig = 1'b0;
    step(3);
    check("rst_dout_a", 32'(dout_a), 32'h0);
    check("rst_dout_b", 32'(dout_b), 32'h0);
    check("rst_upd", 32'({upd_a, upd_b}), 32'h0);
    check("rst_trig", 32'({trig_a, trig_b}), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    res = 1'b0;
    step(3);

    // Exact minimum width on A, upd expected on the third sample after release.
    ua0 = ua_cnt; ub0 = ub_cnt; first_a = -1;
    pulse(1'b0, 32, 10'h2A5);
    for (int i = 1; i <= 6; i++) begin
      step(1);
      if (upd_a && first_a < 0) first_a = i;
      if (i == 3) check("capA_dout_at_upd", 32'(dout_a), 32'h2A5);
    end
    check("capA_latency", 32'(first_a), 32'd3);
    check("capA_upd_count", 32'(ua_cnt - ua0), 32'd1);
    check("capA_no_upd_b", 32'(ub_cnt - ub0), 32'd0);
    check("capA_dout_b", 32'(dout_b), 32'h0);
    check("capA_err", 32'(err), 32'h0);

    // One cycle short on B.
    ub0 = ub_cnt;
    pulse(1'b1, 31, 10'h155);
    step(6);
    check("shortB_no_upd", 32'(ub_cnt - ub0), 32'd0);
    check("shortB_dout_b", 32'(dout_b), 32'h0);
    check("shortB_err", 32'(err), 32'h1);
    check("shortB_dout_a", 32'(dout_a), 32'h2A5);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    check("clr_err", 32'(err), 32'h0);

    // Clear coinciding with the set edge: set must win.
    pulse(1'b1, 10, 10'h0AA);
    step(2);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    check("set_wins", 32'(err), 32'h1);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    check("clr_err2", 32'(err), 32'h0);

    // Overlapping enables for 3 cycles, both widths long enough.
    ua0 = ua_cnt; ub0 = ub_cnt;
    d = 10'h3FF;
    lena = 1'b0; step(37);
    lenb = 1'b0; step(3);
    lena = 1'b1; step(37);
    lenb = 1'b1; step(6);
    check("ovl_no_upd_a", 32'(ua_cnt - ua0), 32'd0);
    check("ovl_no_upd_b", 32'(ub_cnt - ub0), 32'd0);
    check("ovl_dout_a", 32'(dout_a), 32'h2A5);
    check("ovl_dout_b", 32'(dout_b), 32'h0);
    check("ovl_err", 32'(err), 32'h2);
    clr_err = 1'b1; step(1); clr_err = 1'b0;
    check("ovl_clr", 32'(err), 32'h0);

    // Delays: A=5, B=0; second trigger edge two cycles after the first.
    pulse(1'b0, 32, 10'd5);
    step(6);
    check("dly_dout_a", 32'(dout_a), 32'd5);
    trig = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      trig = (k == 1);
      check($sformatf("trig_a_k%0d", k), 32'(trig_a), 32'(k == 6));
      check($sformatf("trig_b_k%0d", k), 32'(trig_b), 32'(k == 1 || k == 3));
    end

    // 100-cycle pulse saturates the width counter; last bus value wins.
    ua0 = ua_cnt;
    d = 10'h111; lena = 1'b0;
    step(50);
    d = 10'h0F0;
    step(50);
    lena = 1'b1; d = 10'h000;
    step(6);
    check("sat_upd", 32'(ua_cnt - ua0), 32'd1);
    check("sat_dout_a", 32'(dout_a), 32'h0F0);

    // Reset in the middle of a pulse; the tail of that pulse must not capture.
    d = 10'h3C3; lena = 1'b0;
    step(10);
    res = 1'b1;
    step(1);
    check("midrst_dout_a", 32'(dout_a), 32'h0);
    check("midrst_upd", 32'({upd_a, upd_b}), 32'h0);
    step(4);
    res = 1'b0;
    ua0 = ua_cnt;
    step(40);
    lena = 1'b1;
    step(6);
    check("midrst_no_upd", 32'(ua_cnt - ua0), 32'd0);
    check("midrst_dout_a_after", 32'(dout_a), 32'h0);
    check("midrst_err", 32'(err), 32'h0);

    // A fresh pulse after reset captures normally.
    pulse(1'b0, 32, 10'h1C3);
    step(6);
    check("post_rst_cap", 32'(dout_a), 32'h1C3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
